// File: rtl/shift_ram_burst_pkg.sv
// Shared types and helpers for the RAM-based burst shift register.
//   state_e   : control FSM state (IDLE accepts samples, BURST replays history)
//   clamp_len : maps a requested replay length onto the legal range 1..depth
package shift_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // A length of 0 still replays the new sample alone.
  // Anything beyond the buffer depth is capped at the whole buffer.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    if (len == 0)     return 1;
    if (len > depth)  return depth;
    return len;
  endfunction

endpackage

// File: rtl/shift_ram_burst_if.sv
// Sample / burst bus of shift_ram_burst.
//   master : sample producer and burst consumer (drives clr, din, sin, len)
//   slave  : the shift register itself (drives dout, dshift, dvalid, dlast,
//            sout, busy, overrun, fill)
interface shift_ram_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();
  logic              clr;
  logic [DATA_W-1:0] din;
  logic              sin;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] dshift;
  logic              dvalid;
  logic              dlast;
  logic              sout;
  logic              busy;
  logic              overrun;
  logic [ADDR_W:0]   fill;

  modport master (
    output clr, din, sin, len,
    input  dout, dshift, dvalid, dlast, sout, busy, overrun, fill
  );

  modport slave (
    input  clr, din, sin, len,
    output dout, dshift, dvalid, dlast, sout, busy, overrun, fill
  );
endinterface

// File: rtl/shift_ram_burst_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk     : clock
//   rst_n   : async active-low reset, clears the read register only
//   we_i    : write enable, writes wdata_i at waddr_i
//   re_i    : read enable, loads mem[raddr_i] into rdata_o
//   rzero_i : synchronously loads 0 into rdata_o (wins over re_i)
//   rdata_o : read data, one cycle after the address
// Array contents are never initialised or reset.
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rzero_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register doubles as the block's data output, so it carries the
  // zero-forcing needed for masked and idle words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rdata_o <= '0;
    else if (rzero_i) rdata_o <= '0;
    else if (re_i)    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/shift_ram_burst.sv
// RAM-based shift register with burst replay.
// Each accepted sample is written into a circular buffer, then the newest
// L samples are replayed oldest-first as one framed burst.
//   clk   : clock
//   rst_n : async active-low reset
//   bus   : slave side of shift_ram_burst_if
//           in : clr (sync clear), din, sin (sample strobe), len (replay length)
//           out: dout (last sample), dshift/dvalid/dlast (burst), sout (burst
//                start), busy, overrun (sticky), fill (valid history count)
module shift_ram_burst
  import shift_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_ram_burst_if.slave bus
);

  localparam int unsigned   DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [ADDR_W-1:0] age_q;     // age of the word being read; counts down to 0
  logic [ADDR_W:0]   fill_q;
  logic              first_q;
  logic              overrun_q;
  logic [DATA_W-1:0] dout_q;
  logic              dvalid_q;
  logic              dlast_q;
  logic              sout_q;

  logic [ADDR_W:0]   len_c;
  logic [ADDR_W-1:0] raddr_d;
  logic [ADDR_W-1:0] age_d;
  logic [ADDR_W:0]   fill_d;
  logic              accept;
  logic              rd_en;
  logic              masked;
  logic              burst_last;

  assign len_c   = (ADDR_W+1)'(clamp_len(32'(bus.len), DEPTH));
  // Oldest word of the burst; L = DEPTH lands on wptr+1 via natural wrap.
  assign raddr_d = wptr_q - len_c[ADDR_W-1:0] + ADDR_W'(1);
  assign age_d   = ADDR_W'(len_c - (ADDR_W+1)'(1));
  assign fill_d  = (fill_q == DEPTH_V) ? fill_q : fill_q + (ADDR_W+1)'(1);

  assign accept     = (state_q == IDLE) && bus.sin && !bus.clr;
  assign rd_en      = (state_q == BURST) && !bus.clr;
  // History older than what was written since the last clear reads as zero.
  assign masked     = {1'b0, age_q} >= fill_q;
  assign burst_last = (age_q == '0);

  // Writes happen only in IDLE and reads only in BURST, so the two ports
  // never touch the same cycle and read-during-write behaviour is moot.
  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .waddr_i (wptr_q),
    .wdata_i (bus.din),
    .re_i    (rd_en),
    .rzero_i (!rd_en || masked),
    .raddr_i (raddr_q),
    .rdata_o (bus.dshift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      raddr_q   <= '0;
      age_q     <= '0;
      fill_q    <= '0;
      first_q   <= 1'b0;
      overrun_q <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      dlast_q   <= 1'b0;
      sout_q    <= 1'b0;
    end else if (bus.clr) begin
      // dout is deliberately held across a clear.
      state_q   <= IDLE;
      wptr_q    <= '0;
      fill_q    <= '0;
      first_q   <= 1'b0;
      overrun_q <= 1'b0;
      dvalid_q  <= 1'b0;
      dlast_q   <= 1'b0;
      sout_q    <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      sout_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.sin) begin
            dout_q  <= bus.din;
            wptr_q  <= wptr_q + ADDR_W'(1);
            fill_q  <= fill_d;
            raddr_q <= raddr_d;
            age_q   <= age_d;
            first_q <= 1'b1;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (bus.sin) overrun_q <= 1'b1;
          // Framing flags ride alongside the RAM read so they line up with
          // the data one cycle later.
          dvalid_q <= 1'b1;
          dlast_q  <= burst_last;
          sout_q   <= first_q;
          first_q  <= 1'b0;
          raddr_q  <= raddr_q + ADDR_W'(1);
          age_q    <= age_q - ADDR_W'(1);
          if (burst_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dvalid  = dvalid_q;
  assign bus.dlast   = dlast_q;
  assign bus.sout    = sout_q;
  assign bus.busy    = (state_q == BURST);
  assign bus.overrun = overrun_q;
  assign bus.fill    = fill_q;

endmodule

// File: tb/tb_shift_ram_burst.sv
module tb_shift_ram_burst;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_ram_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  shift_ram_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       first;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] hist[$];   // samples since last clear, oldest first
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output cycle is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dvalid === 1'b1) begin
        if (sbq.size() == 0) check("unexpected dvalid", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check("dshift", bus.dshift, mon_e.data);
          check("dlast",  bus.dlast,  mon_e.last);
          check("sout",   bus.sout,   mon_e.first);
          check("word cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("idle dshift", {bus.dshift, bus.dlast, bus.sout}, 0);
        if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
          check("missing dvalid", 0, 1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) check("busy timeout", 1, 0);
  endtask

  // Issue one accepted sample and predict its burst from the history list.
  task automatic sample(input logic [7:0] d, input logic [8:0] l);
    int L, age, t;
    logic [7:0] v;
    wait_idle();
    bus.din = d; bus.len = l; bus.sin = 1'b1;
    t = cyc;
    hist.push_back(d);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    if (l == 0) L = 1;
    else if (int'(l) > DEPTH) L = DEPTH;
    else L = int'(l);
    for (int k = 0; k < L; k++) begin
      age = L - 1 - k;
      v = (age < hist.size()) ? hist[hist.size() - 1 - age] : 8'h00;
      sbq.push_back('{data: v, last: (k == L - 1), first: (k == 0), cyc: t + 2 + k});
    end
    @(posedge clk); #1;
    bus.sin = 1'b0;
    check("dout", bus.dout, d);
    check("fill", bus.fill, hist.size());
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    sbq.delete();
    hist.delete();
  endtask

  initial begin
    logic [7:0] held;
    int n;
    bus.clr = 1'b0; bus.sin = 1'b0; bus.din = '0; bus.len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset outputs",
          {bus.dout, bus.dshift, bus.dvalid, bus.dlast, bus.sout, bus.busy, bus.overrun, bus.fill}, 0);

    // Single sample into empty history.
    sample(8'h11, 9'd4);
    wait_idle();

    // Short bursts over a small history.
    do_clr();
    for (int i = 1; i <= 5; i++) sample(8'(i), 9'd3);
    wait_idle();
    check("fill after 5", bus.fill, 5);

    // Saturation and pointer wrap.
    do_clr();
    for (int i = 0; i < 299; i++) sample(8'(i), 9'd1);
    sample(8'h2B, 9'h100);
    wait_idle();
    check("fill saturated", bus.fill, 256);

    // Overrun during a burst, then clear.
    sample(8'hA5, 9'd8);
    @(posedge clk); #1;
    bus.din = 8'($urandom); bus.sin = 1'b1;
    @(posedge clk); #1;
    bus.sin = 1'b0;
    check("overrun set", bus.overrun, 1);
    check("dout held on overrun", bus.dout, 8'hA5);
    wait_idle();
    do_clr();
    check("overrun cleared", bus.overrun, 0);
    check("fill cleared", bus.fill, 0);
    sample(8'h3C, 9'd5);

    // Length clamping.
    sample(8'h5A, 9'd0);
    sample(8'hC3, 9'h1FF);
    wait_idle();

    // Clear in the middle of a burst.
    sample(8'h77, 9'd8);
    @(posedge clk); #1;
    do_clr();
    check("dvalid after clr", bus.dvalid, 0);
    check("busy after clr", bus.busy, 0);
    check("fill after clr", bus.fill, 0);

    // Clear and strobe together: sample dropped.
    held = bus.dout;
    bus.din = 8'hEE; bus.sin = 1'b1; bus.len = 9'd2;
    do_clr();
    bus.sin = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("fill clr+sin", bus.fill, 0);
    check("dout clr+sin", bus.dout, held);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) sample(8'($urandom), 9'($urandom_range(0, 511)));
      else sample(8'($urandom), 9'($urandom_range(0, 20)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) begin wait_idle(); do_clr(); end
    end

    n = 0;
    while (sbq.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    #1;
    check("scoreboard drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
